// File: rtl/tick_accum_pkg.sv
// tick_accum_pkg: shared state encoding, default widths and sum-width helper for tick_accum.
//  Contents: state_t (ST_ACCUM/ST_HOLD), DEF_WIDTH, DEF_LOG2_N, DROP_W, sum_w().
package tick_accum_pkg;
   typedef enum logic {ST_ACCUM = 1'b0, ST_HOLD = 1'b1} state_t;
   localparam int DEF_WIDTH  = 32;
   localparam int DEF_LOG2_N = 3;
   localparam int DROP_W     = 16;
   function automatic int sum_w(input int width, input int log2_n);
      return width + log2_n;
   endfunction
endpackage

// File: rtl/tick_accum_minmax_upd.sv
// minmax_upd: running extreme register (MODE 0 = min, MODE 1 = max) with init/enable.
//  Ports: clk, rst_n (sync, active-low), init (reload neutral value), en (fold d in),
//         d (candidate sample), q (registered extreme), upd (extreme including d, combinational).
module minmax_upd #(
   parameter int WIDTH = 32,
   parameter bit MODE  = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             init,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] upd
);
   // Neutral element: all-ones for min, zero for max, so the first sample always wins.
   localparam logic [WIDTH-1:0] INIT_VAL = MODE ? '0 : '1;
   always_comb upd = (MODE ? (d > q) : (d < q)) ? d : q;
   always_ff @(posedge clk) begin
      if (!rst_n)    q <= INIT_VAL;
      else if (init) q <= INIT_VAL;
      else if (en)   q <= upd;
   end
endmodule

// File: rtl/tick_accum.sv
// tick_accum: batches 2**LOG2_N tick samples into one min/max/mean record with valid/ready.
//  Ports: clk, rst_n (sync, active-low), clear (restart batch), sample_valid/sample_data (input
//         sample strobe), out_valid/out_ready (record handshake), out_min/out_max/out_mean,
//         busy (batch in progress), dropped (samples refused while holding).
//  Option: TICK_ACCUM_DROP_CNT_EN enables the saturating dropped counter; otherwise dropped is 0.
module tick_accum
   import tick_accum_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int LOG2_N = DEF_LOG2_N
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              sample_valid,
   input  logic [WIDTH-1:0]  sample_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_min,
   output logic [WIDTH-1:0]  out_max,
   output logic [WIDTH-1:0]  out_mean,
   output logic              busy,
   output logic [DROP_W-1:0] dropped
);
   localparam int SUM_W = sum_w(WIDTH, LOG2_N);
   localparam logic [LOG2_N:0] LAST = (LOG2_N+1)'((1 << LOG2_N) - 1);
   state_t            state;
   logic [LOG2_N:0]   cnt;
   logic [SUM_W-1:0]  sum, sum_nxt;
   logic [WIDTH-1:0]  min_r, max_r, min_upd, max_upd;
   logic              take, last;
   always_comb take = !clear && state == ST_ACCUM && sample_valid;
   always_comb last = cnt == LAST;
   always_comb sum_nxt = sum + SUM_W'(sample_data);
   always_comb busy = state == ST_ACCUM && cnt != '0;
   // Extremes reload on clear and on the batch-closing sample, in the same edge the record is latched.
   minmax_upd #(.WIDTH(WIDTH), .MODE(1'b0)) u_min (
      .clk(clk), .rst_n(rst_n), .init(clear | (take & last)), .en(take),
      .d(sample_data), .q(min_r), .upd(min_upd)
   );
   minmax_upd #(.WIDTH(WIDTH), .MODE(1'b1)) u_max (
      .clk(clk), .rst_n(rst_n), .init(clear | (take & last)), .en(take),
      .d(sample_data), .q(max_r), .upd(max_upd)
   );
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_ACCUM;
         cnt       <= '0;
         sum       <= '0;
         out_valid <= 1'b0;
         out_min   <= '0;
         out_max   <= '0;
         out_mean  <= '0;
      end else if (clear) begin
         state     <= ST_ACCUM;
         cnt       <= '0;
         sum       <= '0;
         out_valid <= 1'b0;
      end else if (state == ST_ACCUM) begin
         if (sample_valid && last) begin
            out_min   <= min_upd;
            out_max   <= max_upd;
            out_mean  <= sum_nxt[SUM_W-1:LOG2_N];
            out_valid <= 1'b1;
            state     <= ST_HOLD;
            cnt       <= '0;
            sum       <= '0;
         end else if (sample_valid) begin
            sum <= sum_nxt;
            cnt <= cnt + 1'b1;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
         state     <= ST_ACCUM;
      end
   end
`ifdef TICK_ACCUM_DROP_CNT_EN
   // Counts refused samples in HOLD, handshake cycle included; only rst_n clears it.
   always_ff @(posedge clk) begin
      if (!rst_n) dropped <= '0;
      else if (!clear && state == ST_HOLD && sample_valid && dropped != '1) dropped <= dropped + 1'b1;
   end
`else
   always_comb dropped = '0;
`endif
endmodule

// File: tb/tb_tick_accum.sv
module tb_tick_accum;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0, clear = 1'b0, sample_valid = 1'b0, out_ready = 1'b0;
   logic [31:0] sample_data = '0;
   logic        out_valid, busy;
   logic [31:0] out_min, out_max, out_mean;
   logic [15:0] dropped;
   logic        rst8 = 1'b0, clr8 = 1'b0, sv8 = 1'b0, rdy8 = 1'b1;
   logic [31:0] sd8 = '0;
   logic        ov8, busy8;
   logic [31:0] min8, max8, mean8;
   logic [15:0] drop8;
   int n_cmp = 0, n_fail = 0;

   always #5 clk = ~clk;

   tick_accum #(.WIDTH(32), .LOG2_N(2)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .sample_valid(sample_valid),
      .sample_data(sample_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_min(out_min), .out_max(out_max), .out_mean(out_mean), .busy(busy), .dropped(dropped)
   );
   tick_accum dut8 (
      .clk(clk), .rst_n(rst8), .clear(clr8), .sample_valid(sv8),
      .sample_data(sd8), .out_valid(ov8), .out_ready(rdy8),
      .out_min(min8), .out_max(max8), .out_mean(mean8), .busy(busy8), .dropped(drop8)
   );

   typedef struct {
      logic [31:0] s[4];
      logic [31:0] mn, mx, mean;
   } vec_t;
   vec_t vecs[5];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic send(input logic [31:0] s);
      sample_valid = 1'b1;
      sample_data  = s;
      tick();
      sample_valid = 1'b0;
   endtask

   task automatic send8(input logic [31:0] s);
      sv8 = 1'b1;
      sd8 = s;
      tick();
      sv8 = 1'b0;
   endtask

   task automatic accept();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("valid_after_accept", 32'(out_valid), 0);
   endtask

   initial begin
      vecs[0] = '{'{32'd10, 32'd20, 32'd30, 32'd41}, 32'd10, 32'd41, 32'd25};
      vecs[1] = '{'{32'd7, 32'd7, 32'd7, 32'd7}, 32'd7, 32'd7, 32'd7};
      vecs[2] = '{'{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
                  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
      vecs[3] = '{'{32'd5, 32'd3, 32'd9, 32'd1}, 32'd1, 32'd9, 32'd4};
      vecs[4] = '{'{32'd100, 32'd0, 32'd50, 32'd7}, 32'd0, 32'd100, 32'd39};

      tick();
      tick();
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_min", out_min, 0);
      chk("rst_max", out_max, 0);
      chk("rst_mean", out_mean, 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_dropped", 32'(dropped), 0);
      rst_n = 1'b1;
      rst8  = 1'b1;
      tick();

      foreach (vecs[i]) begin
         for (int j = 0; j < 4; j++) begin
            send(vecs[i].s[j]);
            if (j == 2) begin
               chk("busy_mid", 32'(busy), 1);
               chk("valid_early", 32'(out_valid), 0);
            end
         end
         chk("valid", 32'(out_valid), 1);
         chk("min", out_min, vecs[i].mn);
         chk("max", out_max, vecs[i].mx);
         chk("mean", out_mean, vecs[i].mean);
         chk("busy_hold", 32'(busy), 0);
         for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_min", out_min, vecs[i].mn);
            chk("hold_mean", out_mean, vecs[i].mean);
         end
         accept();
      end

      // clear together with 3rd sample restarts the batch
      send(32'd5);
      send(32'd6);
      sample_valid = 1'b1;
      clear = 1'b1;
      sample_data = 32'd99;
      tick();
      sample_valid = 1'b0;
      clear = 1'b0;
      chk("clear_busy", 32'(busy), 0);
      send(32'd1);
      send(32'd2);
      send(32'd3);
      chk("clear_no_early", 32'(out_valid), 0);
      send(32'd4);
      chk("clear_valid", 32'(out_valid), 1);
      chk("clear_min", out_min, 1);
      chk("clear_max", out_max, 4);
      chk("clear_mean", out_mean, 2);
      // clear while holding discards the record
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clear_hold_valid", 32'(out_valid), 0);

      // samples offered during HOLD, including the handshake cycle, are dropped
      for (int j = 0; j < 4; j++) send(32'd1);
      chk("drop_valid", 32'(out_valid), 1);
      send(32'd50);
      send(32'd60);
      out_ready = 1'b1;
      send(32'd70);
      out_ready = 1'b0;
      chk("drop_released", 32'(out_valid), 0);
      chk("drop_busy", 32'(busy), 0);
`ifdef TICK_ACCUM_DROP_CNT_EN
      chk("dropped", 32'(dropped), 3);
`else
      chk("dropped", 32'(dropped), 0);
`endif
      send(32'd2);
      send(32'd2);
      send(32'd2);
      chk("drop_no_early", 32'(out_valid), 0);
      send(32'd2);
      chk("drop_next_valid", 32'(out_valid), 1);
      chk("drop_next_mean", out_mean, 2);
      chk("drop_next_max", out_max, 2);
      accept();

      // default LOG2_N=3 instance: reset mid-batch then 8 samples 0..7
      send8(32'd500);
      send8(32'd400);
      send8(32'd300);
      chk("n8_busy", 32'(busy8), 1);
      rst8 = 1'b0;
      tick();
      chk("n8_rst_busy", 32'(busy8), 0);
      chk("n8_rst_valid", 32'(ov8), 0);
      chk("n8_rst_max", max8, 0);
      rst8 = 1'b1;
      for (int j = 0; j < 8; j++) begin
         send8(32'(j));
         if (j == 6) chk("n8_no_early", 32'(ov8), 0);
      end
      chk("n8_valid", 32'(ov8), 1);
      chk("n8_min", min8, 0);
      chk("n8_max", max8, 7);
      chk("n8_mean", mean8, 3);
      chk("n8_dropped", 32'(drop8), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
